// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and constants.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Quotient reported for a divide by zero.
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Substract_32Bit.sv
// 32-bit subtractor shared with the divider: Result = A - B, Cout = 1 when A >= B.
module Substract_32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        Cout
);

  // Two's-complement subtraction; the carry out is the inverted borrow.
  assign {Cout, Result} = {1'b0, A} + {1'b0, ~B} + 33'd1;

endmodule

// File: rtl/div_step_cnt.sv
// Loadable down-counter that tracks the remaining divide iterations.
module div_step_cnt #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_last
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over decrement; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_last = (cnt == CNT_W'(1));

endmodule

// File: rtl/div_32bit_seq_ctrl.sv
// Unsigned restoring divider sequencer, one quotient bit per clock, using an
// external subtractor that is only claimed while a divide is running.
module div_32bit_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_result,
  input  logic             sub_cout
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [WIDTH-1:0] quot_nxt, rmd_nxt;
  logic             dbz_nxt;
  logic             cnt_load, cnt_dec, is_last;
  logic [WIDTH-1:0] shifted;
  logic             take;

  div_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(WIDTH)),
    .dec      (cnt_dec),
    .is_last  (is_last)
  );

  // Partial remainder shifted left with the next dividend bit; a set MSB of rem
  // means the true value exceeds WIDTH bits and is always >= dvs, so subtract.
  assign shifted = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign take    = rem[WIDTH-1] | sub_cout;

  // Subtractor operands are driven only while iterating.
  assign sub_a = (state == S_RUN) ? shifted : '0;
  assign sub_b = (state == S_RUN) ? dvs     : '0;

  // Status decoded from the state register.
  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN) || (state == S_DONE);
  assign done  = (state == S_DONE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      rem         <= rem_nxt;
      q           <= q_nxt;
      dvs         <= dvs_nxt;
      quotient    <= quot_nxt;
      remainder   <= rmd_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    q_nxt     = q;
    dvs_nxt   = dvs;
    quot_nxt  = quotient;
    rmd_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_nxt = S_RUN;
            rem_nxt   = '0;
            q_nxt     = dividend;
            dvs_nxt   = divisor;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = S_DONE;
            quot_nxt  = WIDTH'(DIV0_QUOT);
            rmd_nxt   = dividend;
            dbz_nxt   = 1'b1;
          end
        end
      end
      S_RUN: begin
        rem_nxt = take ? sub_result : shifted;
        q_nxt   = {q[WIDTH-2:0], take};
        cnt_dec = 1'b1;
        if (is_last) begin
          state_nxt = S_DONE;
          quot_nxt  = q_nxt;
          rmd_nxt   = rem_nxt;
          dbz_nxt   = 1'b0;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_32bit_seq_ctrl.sv
// Directed bench for the sequential divider with the shared subtractor attached.
module tb_div_32bit_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        ready, busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [31:0] sub_a, sub_b, sub_result;
  logic        sub_cout;

  int vec_cnt  = 0;
  int miscomp  = 0;

  always #5 clk = ~clk;

  div_32bit_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .sub_a       (sub_a),
    .sub_b       (sub_b),
    .sub_result  (sub_result),
    .sub_cout    (sub_cout)
  );

  Substract_32Bit u_sub (
    .A      (sub_a),
    .B      (sub_b),
    .Result (sub_result),
    .Cout   (sub_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscomp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Step one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide, wait for done (bounded) and check latency and results.
  // Latency counts the accepting edge as edge 1.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_sub_a", sub_a, 32'd0);
    chk("rst_sub_b", sub_b, 32'd0);

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("d110k_120k", 32'd110000, 32'd120000, 32'd0, 32'd110000, 1'b0, 33);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_div("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
    run_div("d1e9_10", 32'd1000000007, 32'd10, 32'd100000000, 32'd7, 1'b0, 33);
    run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);

    // Abort 1000/3 with a reset at cycle 10.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_sub_b", sub_b, 32'd3);
    for (int i = 2; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_sub_a", sub_a, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // 50/5 with an ignored 7/2 request at cycle 5.
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n     = 1;
    for (int i = 2; i < 5; i++) begin
      tick();
      n++;
    end
    dividend = 32'd7;
    divisor  = 32'd2;
    start    = 1'b1;
    chk("ign_ready", 32'(ready), 32'd0);
    tick();
    n++;
    start = 1'b0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("ign_lat", 32'(n), 32'd33);
    chk("ign_q", quotient, 32'd10);
    chk("ign_r", remainder, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_q", quotient, 32'd10);
    end
    chk("hold_r", remainder, 32'd0);
    chk("hold_ready", 32'(ready), 32'd1);

    // Start held high: issue interval between done pulses.
    dividend = 32'd20;
    divisor  = 32'd6;
    start    = 1'b1;
    n        = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_first_lat", 32'(n), 32'd33);
    n = 0;
    tick();
    n++;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    chk("b2b_period", 32'(n), 32'd34);
    chk("b2b_q", quotient, 32'd3);
    chk("b2b_r", remainder, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
